// File: rtl/picomem_ahb_pkg.sv
// Shared definitions for the AHB-Lite to PicoRV32-native responder:
// bus encodings, FSM states and big-endian strobe/legality helpers.
package picomem_ahb_pkg;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransBusy   = 2'b01;
    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;

    localparam logic [2:0] HsizeByte = 3'b000;
    localparam logic [2:0] HsizeHalf = 3'b001;
    localparam logic [2:0] HsizeWord = 3'b010;

    typedef enum logic [2:0] {
        StIdle,
        StCapt,
        StMem,
        StResp,
        StErr1,
        StErr2
    } state_e;

    // Big-endian lanes: byte offset 0 lives in wdata[31:24], i.e. strobe bit 3.
    function automatic logic [3:0] size_addr_to_wstrb(input logic [2:0] hsize,
                                                      input logic [1:0] addr);
        logic [3:0] strb;
        strb = 4'b0000;
        case (hsize)
            HsizeByte: strb = 4'b1000 >> addr;
            HsizeHalf: strb = addr[1] ? 4'b0011 : 4'b1100;
            HsizeWord: strb = 4'b1111;
            default:   strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic is_legal(input logic [2:0] hsize, input logic [1:0] addr);
        logic ok;
        ok = 1'b0;
        case (hsize)
            HsizeByte: ok = 1'b1;
            HsizeHalf: ok = ~addr[0];
            HsizeWord: ok = (addr == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_picomem_responder.sv
// AHB-Lite slave replaying each single transfer as a PicoRV32-native
// mem_valid/mem_ready request, with a hang-recovery timeout.
module ahb_picomem_responder
    import picomem_ahb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q;
    logic              write_q;
    logic [31:0]       hrdata_q;
    logic              mem_instr_q;
    logic [31:0]       mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_wstrb_q;

    logic accept;
    logic legal;
    logic can_accept;
    logic load;
    logic timed_out;

    // Burst type and HPROT beyond the opcode bit carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{hburst, htrans[0], hprot[3:1]};

    assign accept     = hsel & htrans[1] & hready;
    assign legal      = is_legal(hsize, haddr[1:0]);
    assign can_accept = (state_q == StIdle) || (state_q == StResp) || (state_q == StErr2);
    assign load       = can_accept & accept & legal;
    assign timed_out  = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT));

    always_comb begin
        state_d   = state_q;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state_q)
            StIdle, StResp, StErr2: begin
                hresp = (state_q == StErr2);
                if (accept) begin
                    state_d = legal ? StCapt : StErr1;
                end else begin
                    state_d = StIdle;
                end
            end
            StCapt: begin
                hreadyout = 1'b0;
                state_d   = StMem;
            end
            StMem: begin
                hreadyout = 1'b0;
                if (mem_ready) begin
                    state_d = StResp;
                end else if (timed_out) begin
                    state_d = StErr1;
                end
            end
            StErr1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = StErr2;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            hrdata_q    <= '0;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            // Request fields only move outside MEM, so they stay stable under mem_valid.
            if (load) begin
                write_q     <= hwrite;
                mem_instr_q <= ~hprot[0];
                mem_addr_q  <= {haddr[31:2], 2'b00};
                mem_wstrb_q <= hwrite ? size_addr_to_wstrb(hsize, haddr[1:0]) : 4'b0000;
            end
            if (state_q == StCapt) begin
                cnt_q <= '0;
                if (write_q) begin
                    mem_wdata_q <= hwdata;
                end
            end
            if (state_q == StMem) begin
                cnt_q <= cnt_q + CntW'(1);
                if (mem_ready && !write_q) begin
                    hrdata_q <= mem_rdata;
                end
            end
        end
    end

    assign mem_valid = (state_q == StMem);
    assign mem_instr = mem_instr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_picomem_responder.sv
// Directed bench: main instance with TIMEOUT=4, second instance with the
// timeout disabled; a bus mux picks which one the transfer tasks talk to.
module tb_ahb_picomem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        hsel;
    logic        sel2;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        mr;
    logic [31:0] mem_rdata;

    logic        hreadyout_a, hresp_a, mem_valid_a, mem_instr_a;
    logic [31:0] hrdata_a, mem_addr_a, mem_wdata_a;
    logic [3:0]  mem_wstrb_a;
    logic        hreadyout_b, hresp_b, mem_valid_b, mem_instr_b;
    logic [31:0] hrdata_b, mem_addr_b, mem_wdata_b;
    logic [3:0]  mem_wstrb_b;

    logic        hready;
    logic        cur_hreadyout, cur_hresp, cur_mem_valid, cur_mem_instr;
    logic [31:0] cur_hrdata, cur_mem_addr, cur_mem_wdata;
    logic [3:0]  cur_mem_wstrb;

    assign hready        = sel2 ? hreadyout_b : hreadyout_a;
    assign cur_hreadyout = hready;
    assign cur_hresp     = sel2 ? hresp_b : hresp_a;
    assign cur_mem_valid = sel2 ? mem_valid_b : mem_valid_a;
    assign cur_mem_instr = sel2 ? mem_instr_b : mem_instr_a;
    assign cur_hrdata    = sel2 ? hrdata_b : hrdata_a;
    assign cur_mem_addr  = sel2 ? mem_addr_b : mem_addr_a;
    assign cur_mem_wdata = sel2 ? mem_wdata_b : mem_wdata_a;
    assign cur_mem_wstrb = sel2 ? mem_wstrb_b : mem_wstrb_a;

    int errors = 0;
    int checks = 0;

    ahb_picomem_responder #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .hsel(hsel & ~sel2), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready(hready), .hreadyout(hreadyout_a), .hresp(hresp_a), .hrdata(hrdata_a),
        .mem_valid(mem_valid_a), .mem_instr(mem_instr_a), .mem_ready(mr & ~sel2),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_wstrb(mem_wstrb_a),
        .mem_rdata(mem_rdata)
    );

    ahb_picomem_responder #(.TIMEOUT(0)) dut_nt (
        .clk(clk), .reset(reset), .hsel(hsel & sel2), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready(hready), .hreadyout(hreadyout_b), .hresp(hresp_b), .hrdata(hrdata_b),
        .mem_valid(mem_valid_b), .mem_instr(mem_instr_b), .mem_ready(mr & sel2),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_wstrb(mem_wstrb_b),
        .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one NONSEQ transfer in the current cycle and follows it to its
    // final hreadyout=1 cycle, recording what the native side saw.
    task automatic run_xfer(input logic w, input logic [31:0] a, input logic [2:0] sz,
                            input logic [3:0] prot, input logic [31:0] wd, input int waits,
                            input logic [31:0] rd, output int stall, output int vcyc,
                            output logic [31:0] addr_seen, output logic [3:0] strb_seen,
                            output logic [31:0] wdata_seen, output logic instr_seen,
                            output logic err_seen, output logic resp,
                            output logic [31:0] rdata_out);
        stall = 0; vcyc = 0; addr_seen = '0; strb_seen = '0; wdata_seen = '0;
        instr_seen = 1'b0; err_seen = 1'b0;
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz; hprot = prot;
        step();
        htrans = 2'b00; hwdata = wd; mem_rdata = rd;
        while (cur_hreadyout === 1'b0 && stall < 2000) begin
            if (cur_mem_valid === 1'b1) begin
                if (vcyc == 0) begin
                    addr_seen = cur_mem_addr; strb_seen = cur_mem_wstrb;
                    wdata_seen = cur_mem_wdata; instr_seen = cur_mem_instr;
                end
                mr = (vcyc == waits);
                vcyc++;
            end else begin
                mr = 1'b0;
            end
            if (cur_hresp === 1'b1) err_seen = 1'b1;
            stall++;
            step();
        end
        mr = 1'b0;
        if (stall >= 2000) begin
            checks++; errors++;
            $display("FAIL xfer_bound: hreadyout still %b after %0d cycles, want 1", cur_hreadyout, stall);
        end
        resp = cur_hresp;
        rdata_out = cur_hrdata;
    endtask

    int st, vc;
    logic [31:0] as, wds, rdo;
    logic [3:0]  ss;
    logic        is, es, rs;

    task automatic test_reset();
        reset = 1'b1; hsel = 1'b0; sel2 = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
        hsize = 3'b010; hburst = 3'b000; hprot = 4'b0011; hwdata = '0; mr = 1'b0; mem_rdata = '0;
        step(); step();
        checks++;
        if ({hreadyout_a, hresp_a, mem_valid_a, mem_instr_a, mem_wstrb_a} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 10000000",
                     {hreadyout_a, hresp_a, mem_valid_a, mem_instr_a, mem_wstrb_a});
        end
        checks++;
        if ({hrdata_a, mem_addr_a, mem_wdata_a} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h want 0", hrdata_a, mem_addr_a, mem_wdata_a);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_word();
        run_xfer(1'b1, 32'h1000, 3'b010, 4'b0011, 32'hDEADBEEF, 0, 32'h0,
                 st, vc, as, ss, wds, is, es, rs, rdo);
        checks++;
        if (st !== 2) begin errors++; $display("FAIL word_wr_waits: got %0d want 2", st); end
        checks++;
        if ({as, ss, wds, is} !== {32'h1000, 4'b1111, 32'hDEADBEEF, 1'b0}) begin
            errors++;
            $display("FAIL word_wr_req: got addr %h strb %b wdata %h instr %b want 1000 1111 deadbeef 0",
                     as, ss, wds, is);
        end
        checks++;
        if (rs !== 1'b0) begin errors++; $display("FAIL word_wr_resp: got %b want 0", rs); end
        run_xfer(1'b0, 32'h1000, 3'b010, 4'b0010, 32'h0, 0, 32'hDEADBEEF,
                 st, vc, as, ss, wds, is, es, rs, rdo);
        checks++;
        if ({rdo, rs, es} !== {32'hDEADBEEF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL word_rd: got hrdata %h hresp %b err %b want deadbeef 0 0", rdo, rs, es);
        end
        checks++;
        if ({ss, is, as} !== {4'b0000, 1'b1, 32'h1000}) begin
            errors++;
            $display("FAIL word_rd_req: got strb %b instr %b addr %h want 0000 1 1000", ss, is, as);
        end
        htrans = 2'b00; step();
    endtask

    task automatic test_byte_half();
        logic [3:0] exp_b [4];
        exp_b[0] = 4'b1000; exp_b[1] = 4'b0100; exp_b[2] = 4'b0010; exp_b[3] = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            run_xfer(1'b1, 32'h2000 + 32'(i), 3'b000, 4'b0011, 32'h11223344, 1, 32'h0,
                     st, vc, as, ss, wds, is, es, rs, rdo);
            checks++;
            if ({ss, as, rs} !== {exp_b[i], 32'h2000, 1'b0}) begin
                errors++;
                $display("FAIL byte_wr%0d: got strb %b addr %h resp %b want %b 2000 0",
                         i, ss, as, rs, exp_b[i]);
            end
        end
        run_xfer(1'b1, 32'h2002, 3'b001, 4'b0011, 32'h5566, 0, 32'h0,
                 st, vc, as, ss, wds, is, es, rs, rdo);
        checks++;
        if ({ss, as} !== {4'b0011, 32'h2000}) begin
            errors++; $display("FAIL half_wr2: got strb %b addr %h want 0011 2000", ss, as);
        end
        run_xfer(1'b1, 32'h2000, 3'b001, 4'b0011, 32'h7788, 0, 32'h0,
                 st, vc, as, ss, wds, is, es, rs, rdo);
        checks++;
        if (ss !== 4'b1100) begin errors++; $display("FAIL half_wr0: got strb %b want 1100", ss); end
        htrans = 2'b00; step();
    endtask

    task automatic test_illegal();
        logic [31:0] addrs [3];
        logic [2:0]  sizes [3];
        addrs[0] = 32'h3001; sizes[0] = 3'b010;
        addrs[1] = 32'h3000; sizes[1] = 3'b011;
        addrs[2] = 32'h3003; sizes[2] = 3'b001;
        for (int i = 0; i < 3; i++) begin
            run_xfer(1'b1, addrs[i], sizes[i], 4'b0011, 32'hFFFF_FFFF, 0, 32'h0,
                     st, vc, as, ss, wds, is, es, rs, rdo);
            checks++;
            if (vc !== 0 || st !== 1 || es !== 1'b1 || rs !== 1'b1) begin
                errors++;
                $display("FAIL illegal%0d: got valid %0d stall %0d err1 %b err2 %b want 0 1 1 1",
                         i, vc, st, es, rs);
            end
        end
        htrans = 2'b00; step();
    endtask

    task automatic test_idle_busy();
        logic [1:0] tr [3];
        logic       sl [3];
        tr[0] = 2'b00; sl[0] = 1'b1;
        tr[1] = 2'b01; sl[1] = 1'b1;
        tr[2] = 2'b10; sl[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hsel = sl[i]; htrans = tr[i]; haddr = 32'h6000;
            step();
            checks++;
            if ({cur_hreadyout, cur_hresp, cur_mem_valid} !== 3'b100) begin
                errors++;
                $display("FAIL idle%0d: got rdy/resp/valid %b want 100",
                         i, {cur_hreadyout, cur_hresp, cur_mem_valid});
            end
        end
        hsel = 1'b1; htrans = 2'b00;
    endtask

    task automatic test_back_to_back();
        int st2;
        logic [31:0] rd1;
        run_xfer(1'b0, 32'h4000, 3'b010, 4'b0011, 32'h0, 3, 32'hCAFEF00D,
                 st, vc, as, ss, wds, is, es, rs, rd1);
        run_xfer(1'b1, 32'h4004, 3'b010, 4'b0011, 32'h0BADC0DE, 3, 32'h0,
                 st2, vc, as, ss, wds, is, es, rs, rdo);
        checks++;
        if (st !== 5 || rd1 !== 32'hCAFEF00D) begin
            errors++; $display("FAIL b2b_rd: got stall %0d hrdata %h want 5 cafef00d", st, rd1);
        end
        checks++;
        if (st2 !== 5 || {as, ss, wds} !== {32'h4004, 4'b1111, 32'h0BADC0DE}) begin
            errors++;
            $display("FAIL b2b_wr: got stall %0d addr %h strb %b wdata %h want 5 4004 1111 0badc0de",
                     st2, as, ss, wds);
        end
        htrans = 2'b00; step();
    endtask

    task automatic test_timeout();
        run_xfer(1'b0, 32'h7000, 3'b010, 4'b0011, 32'h0, 100000, 32'h0,
                 st, vc, as, ss, wds, is, es, rs, rdo);
        checks++;
        if (vc !== 5 || st !== 7 || rs !== 1'b1 || es !== 1'b1) begin
            errors++;
            $display("FAIL timeout4: got valid %0d stall %0d err2 %b err1 %b want 5 7 1 1",
                     vc, st, rs, es);
        end
        htrans = 2'b00; step();
        sel2 = 1'b1;
        step();
        run_xfer(1'b0, 32'h7100, 3'b010, 4'b0011, 32'h0, 300, 32'hA5A5_5A5A,
                 st, vc, as, ss, wds, is, es, rs, rdo);
        checks++;
        if (vc !== 301 || rs !== 1'b0 || es !== 1'b0 || rdo !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL no_timeout: got valid %0d resp %b err %b hrdata %h want 301 0 0 a5a55a5a",
                     vc, rs, es, rdo);
        end
        htrans = 2'b00; step();
        sel2 = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h5000; hwrite = 1'b0; hsize = 3'b010;
        step();
        htrans = 2'b00;
        step();
        checks++;
        if (mem_valid_a !== 1'b1) begin
            errors++; $display("FAIL mid_valid: got %b want 1", mem_valid_a);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({mem_valid_a, hreadyout_a, hresp_a, hrdata_a} !== {3'b010, 32'h0}) begin
            errors++;
            $display("FAIL mid_reset: got valid %b rdy %b resp %b hrdata %h want 0 1 0 0",
                     mem_valid_a, hreadyout_a, hresp_a, hrdata_a);
        end
        run_xfer(1'b0, 32'h5008, 3'b010, 4'b0011, 32'h0, 1, 32'h12345678,
                 st, vc, as, ss, wds, is, es, rs, rdo);
        checks++;
        if (st !== 3 || rs !== 1'b0 || rdo !== 32'h12345678 || as !== 32'h5008) begin
            errors++;
            $display("FAIL post_reset_rd: got stall %0d resp %b hrdata %h addr %h want 3 0 12345678 5008",
                     st, rs, rdo, as);
        end
        htrans = 2'b00; step();
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_illegal();
        test_idle_busy();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_picomem_responder.md
# ahb_picomem_responder

AHB-Lite slave that accepts single transfers from the AMBA bus and replays each one as a PicoRV32-native memory request (mem_valid/mem_ready handshake with byte write strobes). It is the responder-side counterpart of the PicoRV32-to-FreeAHB initiator path. It sits between the AHB fabric and any native-interface memory or peripheral, such as on-chip RAM or a simple native-bus register block. It uses the same big-endian byte-lane convention as the initiator side.

## Interface
- TIMEOUT, 255: maximum cycles mem_valid may stay high without mem_ready before an ERROR response is issued; 0 disables the timeout.
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- hsel  in  1  slave select.
- haddr  in  32  AHB address.
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  in  1  1 = write.
- hsize  in  3  000 byte, 001 halfword, 010 word; larger sizes are illegal.
- hburst  in  3  ignored; every beat is handled as a single transfer.
- hprot  in  4  hprot[0]=0 means opcode fetch.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus HREADY (completion of the previous data phase).
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  32  read data.
- mem_valid  out  1  native request.
- mem_instr  out  1  = ~hprot[0] of the captured transfer.
- mem_ready  in  1  native completion.
- mem_addr  out  32  word-aligned address {haddr[31:2],2'b00}.
- mem_wdata  out  32  hwdata, passed through unswapped.
- mem_wstrb  out  4  byte strobes; 0000 means read.
- mem_rdata  in  32  native read data.

## Operation
- **Address phase accept:** a transfer is accepted when hsel & htrans[1] & hready are all high. The block then latches haddr, hwrite, hsize and hprot.
- **IDLE/BUSY or unselected:** no request is made. hreadyout stays 1 and hresp stays 0 (zero-wait OKAY).
- **Illegal transfer:** hsize > 010, a halfword with haddr[0]=1, or a word with haddr[1:0]≠00. No native request is made; the block goes to ERR1 then ERR2.
- **Strobes (big-endian lanes):**
  - Byte at offset o drives wstrb bit (3-o); offset 0 maps to wdata[31:24].
  - Halfword at offset 0 → 1100; halfword at offset 2 → 0011.
  - Word → 1111.
  - Reads → 0000.
- **State machine:**
  - IDLE: hreadyout=1. A legal accept goes to CAPT; an illegal accept goes to ERR1.
  - CAPT: hreadyout=0. Latches hwdata into mem_wdata for writes, sets mem_valid=1 and clears the timeout counter, then goes to MEM.
  - MEM: hreadyout=0, mem_valid=1, counter increments each cycle.
    - mem_ready=1: clear mem_valid; for reads, latch hrdata ← mem_rdata; go to RESP.
    - Counter reaches TIMEOUT with TIMEOUT≠0: clear mem_valid and go to ERR1. This abandoned request is the only permitted protocol violation, used for hang recovery.
  - RESP: hreadyout=1, hresp=0. A legal accept this cycle goes to CAPT, an illegal accept to ERR1, otherwise IDLE.
  - ERR1: hresp=1, hreadyout=0; go to ERR2.
  - ERR2: hresp=1, hreadyout=1. Accepts like RESP. Any transfer accepted in this cycle is handled normally.
- **Native handshake rules:**
  - mem_ready is sampled only while mem_valid=1.
  - mem_addr, mem_wdata, mem_wstrb and mem_instr are stable while mem_valid=1.
- **hrdata** holds its value until the next read completes. It is undefined-but-stable after a write.
- **Reset:** reset asserted in any state, including MEM, returns to IDLE in the next cycle. All outputs return to reset values and any in-flight native request is dropped.
- **Reset values:** hreadyout=1, hresp=0, hrdata=0, mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.

## Timing
- **Legal transfer:** address phase in cycle 0; CAPT in cycle 1; mem_valid rises at the edge ending cycle 1.
- **Zero-wait memory:** if mem_ready=1 in cycle 2, RESP is in cycle 3. This gives two AHB wait states minimum; each extra memory wait cycle adds one.
- **Back-to-back transfers:** a transfer accepted in RESP or ERR2 enters CAPT the next cycle, with no idle gap.
- **Error:** 2-cycle ERROR response, in cycles 1 and 2 after the address phase.
- **Timeout:** ERR1 starts TIMEOUT+1 cycles after mem_valid rises. The counter width is $clog2(TIMEOUT+1), minimum 1.

## Structure
- **Shared package `picomem_ahb_pkg`:**
  - HTRANS and HSIZE constants.
  - State enum: IDLE, CAPT, MEM, RESP, ERR1, ERR2.
  - Function `size_addr_to_wstrb(hsize, addr[1:0])`.
  - Function `is_legal(hsize, addr[1:0])`.
- **Sub-modules:** none; a single module. Strobe generation uses the package function.

## Test plan
- **Word write/read:** NONSEQ word write 0x1000 / 0xDEADBEEF with mem_ready after 0 waits → mem_wstrb=1111, mem_addr=0x1000, hreadyout low for exactly 2 cycles. A read-back of mem_rdata=0xDEADBEEF → hrdata=0xDEADBEEF with hresp=0.
- **Byte writes:** byte writes at 0x2000…0x2003 → wstrb 1000, 0100, 0010, 0001 in order, mem_addr=0x2000 each time. Halfword writes at 0x2002 → 0011.
- **Illegal transfers:** word at 0x3001 → no mem_valid; hresp=1 for 2 cycles with hreadyout 0 then 1. The same holds for hsize=011.
- **Stalled memory:** with TIMEOUT=4 and mem_ready never asserted → mem_valid high for 5 cycles, then the ERROR response. With TIMEOUT=0 and mem_ready after 300 cycles → OKAY response.
- **Back-to-back and idle:** back-to-back NONSEQ read/write with 3 memory waits each → the second CAPT immediately follows RESP. IDLE/BUSY transfers in between → hreadyout stays 1 and no mem_valid.
- **Reset mid-operation:** reset asserted in MEM → next cycle mem_valid=0, hreadyout=1, hresp=0, hrdata=0. A subsequent word read completes normally.
